vending_machine: RTL and testbench
==================================

VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 The block SHALL have no parameters; the price is fixed at 25 cents, and all money is expressed in 5-cent units.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port `clk`: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-005 Port `cin`: input, 3 bits, coin code sampled every rising edge.
  - Codes: 0 = none, 1 = nickel (5), 2 = dime (10), 3 = nickel+dime (15), 4 = dime+dime (20), 5 = quarter (25).
REQ-006 Port `change`: output, 3 bits, change returned during a vend cycle, using the same code table as `cin`.
REQ-007 Port `current_state`: output, 3 bits, the credit state register.
  - Codes: 0 = IDLE (0c), 1 = FIVE, 2 = TEN, 3 = FIFTEEN, 4 = TWENTY.
REQ-008 Port `product`: output, 1 bit, dispense pulse.

Function
REQ-009 On each rising edge with `reset` = 0, the block SHALL compute total = credit(current_state) + value(cin).
REQ-010 If total < 25, the block SHALL set the next state to total/5, and register `product` = 0 and `change` = 0.
REQ-011 If total >= 25, the block SHALL set the next state to IDLE, and register `product` = 1 and `change` = code of (total − 25).
  - Range of change: 0..20c, codes 0..4; the maximum case is TWENTY + quarter giving `change` = 4.
REQ-012 `product` and `change` SHALL be registered outputs.
  - Both are valid for exactly the one cycle following the edge that sampled the completing coin.
  - Both are 0 in every other cycle; consecutive vending coins give consecutive pulses.
REQ-013 `current_state` SHALL be driven directly from the state register; it has zero combinational logic on the output path.
REQ-014 `cin` = 0, 6 or 7 SHALL be treated as no coin: state holds, `product` = 0 and `change` = 0.
REQ-015 State code 5 (TWENTY_FIVE) SHALL be reserved and never entered; register values 5–7 SHALL transition to IDLE on the next edge with `product` = 0 and `change` = 0.
REQ-016 Credit SHALL never exceed 20c in the state register.
  - No overflow is possible: the maximum total is 45c, which fits a 4-bit nickel-count datapath.
REQ-017 The block SHALL place no constraint on back-to-back coins; a coin may be accepted every cycle.

Reset
REQ-018 When `reset` = 1 at a rising edge, the block SHALL set `current_state` = IDLE, `product` = 0 and `change` = 0.
  - Any coin sampled on that edge is discarded, including a coin present when reset occurs mid-credit.
REQ-019 The block SHALL give reset priority over all coin processing.
REQ-020 Before the first reset, outputs SHALL be treated as unknown; a bench must apply reset first.

Structure
REQ-021 A shared package `vending_pkg` SHALL hold the following constants:
  - state encodings IDLE, FIVE, TEN, FIFTEEN, TWENTY, TWENTY_FIVE (reserved);
  - coin/change encodings ZERO, NICKEL, DIME, NICKEL_DIME, DIME_DIME, QUARTER;
  - PRICE_UNITS = 5.
REQ-022 One sub-module `vending_coin_value` SHALL map a 3-bit coin code to a 4-bit nickel count, returning 0 for codes 0, 6 and 7.
REQ-023 The top level SHALL consist of the following, with no latches or multi-driver nets:
  - one combinational next-state/output block;
  - one clocked register block holding `current_state`, `product` and `change`.

Verification
REQ-024 Reset, then `cin` = 0 for two cycles -> `current_state` = 0, `product` = 0, `change` = 0 throughout.
REQ-025 From IDLE, quarter (5) -> next cycle `product` = 1, `change` = 0, `current_state` = 0; the following cycle with no coin -> `product` = 0.
REQ-026 From IDLE, nickel (1) then quarter (5):
  - after the nickel: `current_state` = 1;
  - after the quarter: `product` = 1, `change` = 1 (5c), `current_state` = 0.
REQ-027 From IDLE, dime+dime (4) then quarter (5):
  - after dime+dime: `current_state` = 4;
  - after the quarter: `product` = 1, `change` = 4 (20c), state IDLE.
REQ-028 From IDLE, nickel, dime, dime -> states 1, 3, then vend with `product` = 1, `change` = 0, state IDLE; illegal `cin` = 7 at state 3 -> state stays 3, no vend.
REQ-029 Credit at TEN, then `reset` = 1 together with `cin` = 5 -> `current_state` = 0, `product` = 0, `change` = 0 (coin discarded).

Source files
------------

// File: rtl/vending_pkg.sv
// Shared encodings for the 25c vending machine: credit states, coin/change codes and price.
// All money is counted in nickels (5c units); helpers map between codes and nickel counts.
package vending_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FIVE        = 3'd1,
        TEN         = 3'd2,
        FIFTEEN     = 3'd3,
        TWENTY      = 3'd4,
        TWENTY_FIVE = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ZERO        = 3'd0,
        NICKEL      = 3'd1,
        DIME        = 3'd2,
        NICKEL_DIME = 3'd3,
        DIME_DIME   = 3'd4,
        QUARTER     = 3'd5
    } coin_e;

    localparam logic [3:0] PRICE_UNITS = 4'd5;

    // Credit held by a state, in nickels; reserved/unused encodings carry no credit.
    function automatic logic [3:0] state_credit(input state_e s);
        logic [3:0] units;
        units = 4'd0;
        case (s)
            FIVE:    units = 4'd1;
            TEN:     units = 4'd2;
            FIFTEEN: units = 4'd3;
            TWENTY:  units = 4'd4;
            default: units = 4'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/vending_coin_value.sv
// Maps a 3-bit coin code to its value in nickels; codes 0, 6 and 7 are worth nothing.
// Purely combinational, no flow control.
module vending_coin_value
    import vending_pkg::*;
(
    input  logic [2:0] coin_i,
    output logic [3:0] units_o
);

    always_comb begin
        units_o = 4'd0;
        case (coin_i)
            NICKEL:      units_o = 4'd1;
            DIME:        units_o = 4'd2;
            NICKEL_DIME: units_o = 4'd3;
            DIME_DIME:   units_o = 4'd4;
            QUARTER:     units_o = 4'd5;
            default:     units_o = 4'd0;
        endcase
    end

endmodule

// File: rtl/vending_machine.sv
// 25c vending FSM: accumulates coins, pulses product and returns change one cycle after the completing coin.
// Accepts a coin every cycle with no backpressure; reset discards the coin on the same edge.
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] cin,
    output logic [2:0] change,
    output logic [2:0] current_state,
    output logic       product
);

    state_e     state_q, state_d;
    logic       product_q, product_d;
    logic [2:0] change_q, change_d;

    logic [3:0] coin_units;
    logic [3:0] total_units;

    vending_coin_value u_coin_value (
        .coin_i  (cin),
        .units_o (coin_units)
    );

    // Worst case is TWENTY + quarter = 9 nickels, so 4 bits never overflow.
    assign total_units = state_credit(state_q) + coin_units;

    always_comb begin
        state_d   = state_q;
        product_d = 1'b0;
        change_d  = ZERO;
        if (state_q > TWENTY) begin
            state_d = IDLE;
        end else if (total_units >= PRICE_UNITS) begin
            state_d   = IDLE;
            product_d = 1'b1;
            change_d  = 3'(total_units - PRICE_UNITS);
        end else begin
            state_d = state_e'(total_units[2:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            product_q <= 1'b0;
            change_q  <= ZERO;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
            change_q  <= change_d;
        end
    end

    assign current_state = state_q;
    assign product       = product_q;
    assign change        = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: hand-computed vectors for each coin sequence,
// sampled 1ns after the rising edge that registered them.
module tb_vending_machine;

    logic       clk;
    logic       reset;
    logic [2:0] cin;
    logic [2:0] change;
    logic [2:0] current_state;
    logic       product;

    int checks = 0;
    int errors = 0;

    vending_machine dut (
        .clk           (clk),
        .reset         (reset),
        .cin           (cin),
        .change        (change),
        .current_state (current_state),
        .product       (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input logic r, input logic [2:0] c);
        @(negedge clk);
        reset = r;
        cin   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect3(input string tag, input logic [2:0] st, input logic p, input logic [2:0] ch);
        check({tag, ".state"},   current_state, st);
        check({tag, ".product"}, {2'b00, product}, {2'b00, p});
        check({tag, ".change"},  change, ch);
    endtask

    initial begin
        reset = 1'b1;
        cin   = 3'd0;

        tick(1'b1, 3'd0); expect3("reset",      3'd0, 1'b0, 3'd0);
        tick(1'b0, 3'd0); expect3("idle1",      3'd0, 1'b0, 3'd0);
        tick(1'b0, 3'd0); expect3("idle2",      3'd0, 1'b0, 3'd0);

        tick(1'b0, 3'd5); expect3("q_vend",     3'd0, 1'b1, 3'd0);
        tick(1'b0, 3'd0); expect3("q_after",    3'd0, 1'b0, 3'd0);

        tick(1'b0, 3'd1); expect3("n_credit",   3'd1, 1'b0, 3'd0);
        tick(1'b0, 3'd5); expect3("nq_vend",    3'd0, 1'b1, 3'd1);

        tick(1'b0, 3'd4); expect3("dd_credit",  3'd4, 1'b0, 3'd0);
        tick(1'b0, 3'd5); expect3("ddq_vend",   3'd0, 1'b1, 3'd4);

        tick(1'b0, 3'd1); expect3("n1",         3'd1, 1'b0, 3'd0);
        tick(1'b0, 3'd2); expect3("nd",         3'd3, 1'b0, 3'd0);
        tick(1'b0, 3'd7); expect3("illegal7",   3'd3, 1'b0, 3'd0);
        tick(1'b0, 3'd2); expect3("ndd_vend",   3'd0, 1'b1, 3'd0);

        tick(1'b0, 3'd5); expect3("b2b_1",      3'd0, 1'b1, 3'd0);
        tick(1'b0, 3'd5); expect3("b2b_2",      3'd0, 1'b1, 3'd0);

        tick(1'b0, 3'd4); expect3("t20",        3'd4, 1'b0, 3'd0);
        tick(1'b0, 3'd2); expect3("t20_dime",   3'd0, 1'b1, 3'd1);

        tick(1'b0, 3'd3); expect3("t15",        3'd3, 1'b0, 3'd0);
        tick(1'b0, 3'd4); expect3("t15_dd",     3'd0, 1'b1, 3'd2);

        tick(1'b0, 3'd2); expect3("ten",        3'd2, 1'b0, 3'd0);
        tick(1'b0, 3'd6); expect3("illegal6",   3'd2, 1'b0, 3'd0);
        tick(1'b1, 3'd5); expect3("rst_coin",   3'd0, 1'b0, 3'd0);
        tick(1'b0, 3'd0); expect3("post_rst",   3'd0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
